// File: rtl/rx_sample_streamer_if.sv
// Byte stream from the RX sample streamer toward the host FIFO bridge.
// One byte moves on every clock where tx_valid and tx_ready are both high.
interface rx_sample_streamer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/rx_sample_streamer.sv
// Captures ADC samples into a FIFO, tags each shot's first sample,
// and streams them to the host as two bytes per sample.
module rx_sample_streamer #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  rx_read,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  pull_data,
    rx_sample_streamer_if.master  tx,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
    output logic                  frame_active
);
    localparam int EW = DATA_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, FETCH, HI, LO} state_t;

    state_t                state, state_n;
    logic                  enable_q;
    logic                  pend;
    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic [EW-1:0]         mem [2**ADDR_WIDTH];
    logic [EW-1:0]         rd_q;
    logic [7:0]            low_byte, low_byte_n;
    logic [7:0]            data_n;
    logic                  valid_n;
    logic                  pop;
    logic                  rise;
    logic                  push_req;
    logic                  push_ok;
    logic                  drop;
    logic                  full;

    assign rise     = enable & ~enable_q;
    assign full     = (fifo_count == DEPTH);
    assign push_req = frame_active & rx_read;
    // A pop in the same cycle frees the slot a full FIFO would lack.
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_ff @(posedge clock) begin
        if (push_ok) mem[wptr] <= {pend, adc_data};
        if (pop) rd_q <= mem[rptr];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enable_q     <= 1'b0;
            frame_active <= 1'b0;
            pend         <= 1'b0;
            overflow     <= 1'b0;
            wptr         <= '0;
            rptr         <= '0;
            fifo_count   <= '0;
        end else begin
            enable_q <= enable;
            if (rise) frame_active <= 1'b1;
            else if (!enable) frame_active <= 1'b0;
            if (rise) pend <= 1'b1;
            else if (push_ok) pend <= 1'b0;
            if (rise) overflow <= 1'b0;
            else if (drop) overflow <= 1'b1;
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + ONE;
                2'b01:   fifo_count <= fifo_count - ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            tx.tx_data  <= '0;
            tx.tx_valid <= 1'b0;
            low_byte    <= '0;
        end else begin
            state       <= state_n;
            tx.tx_data  <= data_n;
            tx.tx_valid <= valid_n;
            low_byte    <= low_byte_n;
        end
    end

    always_comb begin
        state_n    = state;
        pop        = 1'b0;
        valid_n    = tx.tx_valid;
        data_n     = tx.tx_data;
        low_byte_n = low_byte;
        unique case (state)
            IDLE: begin
                if (pull_data && fifo_count != '0) begin
                    pop     = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                low_byte_n = rd_q[7:0];
                data_n     = {1'b1, rd_q[DATA_WIDTH],
                              6'(rd_q[DATA_WIDTH-1:0] >> 8)};
                valid_n    = 1'b1;
                state_n    = HI;
            end
            HI: begin
                if (tx.tx_ready) begin
                    data_n  = low_byte;
                    state_n = LO;
                end
            end
            LO: begin
                if (tx.tx_ready) begin
                    valid_n = 1'b0;
                    if (pull_data && fifo_count != '0) begin
                        pop     = 1'b1;
                        state_n = FETCH;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rx_sample_streamer.sv
// Directed/random bench for rx_sample_streamer.
// Expected bytes come from a queue built from the capture rules.
module tb_rx_sample_streamer;
    localparam int DW = 10;
    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          rx_read;
    logic [DW-1:0] adc_data;
    logic          pull_data;
    logic [AW:0]   fifo_count;
    logic          overflow;
    logic          frame_active;

    rx_sample_streamer_if tx ();

    rx_sample_streamer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .rx_read     (rx_read),
        .adc_data    (adc_data),
        .pull_data   (pull_data),
        .tx          (tx),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .frame_active(frame_active)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    int         rdy_pct = 100;
    int         m_inbuf = 0;
    bit         m_tag = 1'b0;
    bit         m_ovf = 1'b0;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(negedge clock);
        tx.tx_ready = ($urandom_range(0, 99) < rdy_pct);
    endtask

    // Stored samples: sync bit, shot tag, upper bits, then low byte.
    task automatic capture(input logic [DW-1:0] d, input bit pop_now);
        rx_read  = 1'b1;
        adc_data = d;
        if (m_inbuf < DEPTH || pop_now) begin
            exp_q.push_back({1'b1, m_tag, 6'(d >> 8)});
            exp_q.push_back(d[7:0]);
            m_tag = 1'b0;
            m_inbuf++;
        end else begin
            m_ovf = 1'b1;
        end
        step();
    endtask

    task automatic frame_rise();
        enable = 1'b0;
        step();
        chk("frame_low", 32'(frame_active), 0);
        enable = 1'b1;
        step();
        m_tag = 1'b1;
        m_ovf = 1'b0;
        chk("frame_high", 32'(frame_active), 1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || tx.tx_valid) && n < budget) begin
            step();
            n++;
        end
        chk("drain_done", 32'(exp_q.size()), 0);
        repeat (3) step();
    endtask

    initial begin : mon
        logic       pv;
        logic       pr;
        logic [7:0] pd;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        forever begin
            @(negedge clock);
            #1;
            if (!reset_n) begin
                pv = 1'b0;
                pr = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("hold_valid", 32'(tx.tx_valid), 1);
                    chk("hold_data", 32'(tx.tx_data), 32'(pd));
                end
                if (tx.tx_valid && !pv) m_inbuf--;
                if (tx.tx_valid && tx.tx_ready) begin
                    if (exp_q.size() == 0)
                        chk("stray_byte", 32'(tx.tx_valid), 0);
                    else
                        chk("byte", 32'(tx.tx_data), 32'(exp_q.pop_front()));
                end
                pv = tx.tx_valid;
                pr = tx.tx_ready;
                pd = tx.tx_data;
            end
        end
    end

    initial begin : stim
        int n;
        reset_n     = 1'b0;
        enable      = 1'b0;
        rx_read     = 1'b0;
        adc_data    = '0;
        pull_data   = 1'b0;
        tx.tx_ready = 1'b1;
        repeat (3) step();
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_frame", 32'(frame_active), 0);
        chk("rst_valid", 32'(tx.tx_valid), 0);
        chk("rst_data", 32'(tx.tx_data), 0);
        reset_n = 1'b1;
        step();

        // Four directed samples, byte0 appears two edges after capture
        pull_data = 1'b1;
        rdy_pct   = 100;
        frame_rise();
        capture(10'h3FF, 1'b0);
        chk("lat_e0", 32'(tx.tx_valid), 0);
        capture(10'h001, 1'b0);
        chk("lat_e1", 32'(tx.tx_valid), 0);
        capture(10'h155, 1'b0);
        chk("lat_e2_valid", 32'(tx.tx_valid), 1);
        chk("lat_e2_byte0", 32'(tx.tx_data), 32'h0C3);
        capture(10'h2AA, 1'b0);
        rx_read = 1'b0;
        drain(100);
        chk("t1_count", 32'(fifo_count), 0);

        // Buffer ten samples with pull off, then stream them out
        pull_data = 1'b0;
        for (int i = 0; i < 10; i++)
            capture(DW'($urandom_range(0, 1023)), 1'b0);
        rx_read = 1'b0;
        repeat (2) step();
        chk("t2_count10", 32'(fifo_count), 10);
        chk("t2_novalid", 32'(tx.tx_valid), 0);
        pull_data = 1'b1;
        drain(200);
        chk("t2_count0", 32'(fifo_count), 0);

        // Random back-pressure with gaps between captures
        frame_rise();
        rdy_pct = 30;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                capture(DW'($urandom_range(0, 1023)), 1'b0);
            end else begin
                rx_read = 1'b0;
                step();
            end
        end
        rx_read = 1'b0;
        drain(1000);
        chk("t3_count0", 32'(fifo_count), 0);

        // Fill past full with no draining
        pull_data = 1'b0;
        rdy_pct   = 0;
        frame_rise();
        for (int i = 0; i < DEPTH + 3; i++)
            capture(DW'(i), 1'b0);
        rx_read = 1'b0;
        step();
        chk("t4_full", 32'(fifo_count), DEPTH);
        chk("t4_ovf", 32'(overflow), 1);
        chk("t4_ovf_model", 32'(overflow), 32'(m_ovf));
        frame_rise();
        chk("t4_ovf_clr", 32'(overflow), 0);
        chk("t4_kept", 32'(fifo_count), DEPTH);

        // Push and pop together while full
        pull_data = 1'b1;
        capture(10'h1A5, 1'b1);
        rx_read = 1'b0;
        chk("t5_count", 32'(fifo_count), DEPTH);
        chk("t5_ovf", 32'(overflow), 0);
        rdy_pct = 100;
        drain(4000);
        chk("t5_count0", 32'(fifo_count), 0);

        // Reset while byte1 is waiting for acceptance
        rdy_pct = 0;
        for (int i = 0; i < 3; i++)
            capture(DW'($urandom_range(0, 1023)), 1'b0);
        rx_read = 1'b0;
        n = 0;
        while (!tx.tx_valid && n < 20) begin
            step();
            n++;
        end
        chk("t6_valid_seen", 32'(tx.tx_valid), 1);
        rdy_pct = 100;
        step();
        rdy_pct = 0;
        step();
        chk("t6_byte1_valid", 32'(tx.tx_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(tx.tx_valid), 0);
        chk("t6_rst_count", 32'(fifo_count), 0);
        exp_q.delete();
        m_inbuf = 0;
        m_tag   = 1'b1;
        step();
        step();
        reset_n = 1'b1;
        rdy_pct = 100;
        repeat (20) step();
        chk("t6_quiet_valid", 32'(tx.tx_valid), 0);
        chk("t6_quiet_count", 32'(fifo_count), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
